// File: rtl/ball_motion_engine_if.sv
// Map ROM query bus: the engine drives the tile index, the ROM answers with
// the tile code one cycle later.
interface ball_motion_engine_if #(
   parameter int XI_W = 3,
   parameter int YI_W = 11
);
   logic [XI_W-1:0] map_index_x;
   logic [YI_W-1:0] map_index_y;
   logic [2:0]      map_state;

   modport master (output map_index_x, output map_index_y, input map_state);
   modport slave  (input map_index_x, input map_index_y, output map_state);
endinterface

// File: rtl/ball_motion_engine.sv
// Frame-driven ball controller: lateral/forward motion, bounce physics and
// tile-driven ground/air/fall/dead state, one three-cycle update per tick.
module ball_motion_engine #(
   parameter int LANES        = 5,
   parameter int LANE_W       = 100,
   parameter int X_STEP       = 4,
   parameter int Y_W          = 16,
   parameter int ROW_SHIFT    = 5,
   parameter int SPEED        = 2,
   parameter int BOOST_FRAMES = 120,
   parameter int JUMP_V       = 12,
   parameter int GRAVITY      = 1,
   parameter int FALL_FRAMES  = 30,
   localparam int X_MAX = (LANES-1)*LANE_W,
   localparam int XW    = $clog2(X_MAX+1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tick,
   input  logic                   move_left,
   input  logic                   move_right,
   input  logic                   pause,
   ball_motion_engine_if.master   rom,
   output logic [XW-1:0]          x_ball,
   output logic [Y_W-1:0]         y_ball,
   output logic [8:0]             y_pixel_offset,
   output logic [1:0]             state,
   output logic                   boosted,
   output logic                   busy,
   output logic                   fail
);
   typedef enum logic [1:0] {GROUND = 2'd0, AIR = 2'd1, FALL = 2'd2, DEAD = 2'd3} state_t;

   localparam int XIW   = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int BW    = $clog2(BOOST_FRAMES+1);
   localparam int FW    = $clog2(FALL_FRAMES+1);
   localparam int VW    = 12;
   localparam int X_RST = ((X_MAX/2)/LANE_W)*LANE_W;

   state_t                  st_q;
   logic [XW-1:0]           x_q, x_d;
   logic [Y_W-1:0]          y_q, y_d;
   logic [8:0]              off_q, off_d;
   logic signed [VW-1:0]    vz_q, vz_d;
   logic [BW-1:0]           boost_q, boost_d;
   logic [FW-1:0]           fall_q, fall_d;
   logic                    land_q, land_d;
   logic                    fail_q, boosted_q, ml_q, mr_q;
   logic [XIW-1:0]          ix_q, ix_d;
   logic [Y_W-ROW_SHIFT-1:0] iy_q, iy_d;
   logic [2:0]              vld_pipe;
   logic                    accept;
   int                      sum;

   assign accept = tick && (vld_pipe == '0) && !pause && (st_q != DEAD);

   // Phase U next-state; the query index is taken from the updated position so
   // the synchronous ROM answer lines up with phase E.
   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      off_d   = off_q;
      vz_d    = vz_q;
      land_d  = land_q;
      boost_d = boost_q;
      fall_d  = fall_q;
      sum     = int'(off_q) + int'(vz_q);
      if (st_q != FALL) begin
         if (mr_q && !ml_q)
            x_d = (int'(x_q) + X_STEP > X_MAX) ? XW'(X_MAX) : XW'(int'(x_q) + X_STEP);
         else if (ml_q && !mr_q)
            x_d = (int'(x_q) < X_STEP) ? '0 : XW'(int'(x_q) - X_STEP);
         y_d = y_q + (boosted_q ? Y_W'(2*SPEED) : Y_W'(SPEED));
      end
      if (boost_q != '0) boost_d = boost_q - 1'b1;
      if (st_q == AIR) begin
         if (sum <= 0) begin
            off_d  = '0;
            land_d = 1'b1;
         end else begin
            off_d = (sum > 511) ? 9'd511 : 9'(sum);
         end
         vz_d = vz_q - VW'(GRAVITY);
      end
      if (st_q == FALL && fall_q != '0) fall_d = fall_q - 1'b1;
      ix_d = XIW'((int'(x_d) + LANE_W/2) / LANE_W);
      iy_d = y_d[Y_W-1:ROW_SHIFT];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q      <= GROUND;
         x_q       <= XW'(X_RST);
         y_q       <= '0;
         off_q     <= '0;
         vz_q      <= '0;
         boost_q   <= '0;
         fall_q    <= '0;
         land_q    <= 1'b0;
         fail_q    <= 1'b0;
         boosted_q <= 1'b0;
         ml_q      <= 1'b0;
         mr_q      <= 1'b0;
         ix_q      <= XIW'(X_RST/LANE_W);
         iy_q      <= '0;
         vld_pipe  <= '0;
      end else begin
         vld_pipe <= {vld_pipe[1:0], accept};
         if (accept) begin
            ml_q <= move_left;
            mr_q <= move_right;
         end
         if (vld_pipe[0]) begin
            x_q       <= x_d;
            y_q       <= y_d;
            off_q     <= off_d;
            vz_q      <= vz_d;
            land_q    <= land_d;
            boost_q   <= boost_d;
            boosted_q <= (boost_d != '0);
            fall_q    <= fall_d;
            ix_q      <= ix_d;
            iy_q      <= iy_d;
         end
         // Airborne frames only look at the tile on the landing frame.
         if (vld_pipe[2]) begin
            if (st_q == GROUND || (st_q == AIR && land_q)) begin
               land_q <= 1'b0;
               case (rom.map_state)
                  3'd0: begin
                     st_q   <= FALL;
                     fall_q <= FW'(FALL_FRAMES);
                     vz_q   <= '0;
                  end
                  3'd2: begin
                     st_q <= AIR;
                     vz_q <= VW'(JUMP_V);
                  end
                  3'd3: begin
                     st_q      <= GROUND;
                     vz_q      <= '0;
                     boost_q   <= BW'(BOOST_FRAMES);
                     boosted_q <= 1'b1;
                  end
                  default: begin
                     st_q <= GROUND;
                     vz_q <= '0;
                  end
               endcase
            end else if (st_q == FALL && fall_q == '0) begin
               st_q   <= DEAD;
               fail_q <= 1'b1;
            end
         end
      end
   end

   assign rom.map_index_x = ix_q;
   assign rom.map_index_y = iy_q;
   assign x_ball          = x_q;
   assign y_ball          = y_q;
   assign y_pixel_offset  = off_q;
   assign state           = st_q;
   assign boosted         = boosted_q;
   assign busy            = |vld_pipe;
   assign fail            = fail_q;
endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed + randomized bench for ball_motion_engine with a frame-level model.
module tb_ball_motion_engine;
   localparam int LANES = 5, LANE_W = 100, X_STEP = 4, Y_W = 16, ROW_SHIFT = 5;
   localparam int SPEED = 2, BOOST_FRAMES = 120, JUMP_V = 12, GRAVITY = 1, FALL_FRAMES = 30;
   localparam int X_MAX = (LANES-1)*LANE_W;
   localparam int ROWS  = 1 << (Y_W-ROW_SHIFT);

   logic clk, rst, tick, move_left, move_right, pause;
   logic [8:0]     x_ball;
   logic [Y_W-1:0] y_ball;
   logic [8:0]     y_pixel_offset;
   logic [1:0]     state;
   logic           boosted, busy, fail;

   ball_motion_engine_if #(.XI_W(3), .YI_W(Y_W-ROW_SHIFT)) mif ();

   ball_motion_engine dut (
      .clk(clk), .rst(rst), .tick(tick), .move_left(move_left), .move_right(move_right),
      .pause(pause), .rom(mif), .x_ball(x_ball), .y_ball(y_ball),
      .y_pixel_offset(y_pixel_offset), .state(state), .boosted(boosted), .busy(busy),
      .fail(fail)
   );

   bit [2:0] map_mem [0:ROWS-1][0:LANES-1];

   always_ff @(posedge clk)
      mif.map_state <= map_mem[mif.map_index_y][(int'(mif.map_index_x) < LANES) ? int'(mif.map_index_x) : 0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int m_x, m_y, m_off, m_st, m_vz, m_boost, m_fall, m_land, m_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic fill_map(input bit [2:0] t);
      for (int r = 0; r < ROWS; r++)
         for (int l = 0; l < LANES; l++) map_mem[r][l] = t;
   endtask

   task automatic set_row(input int r, input bit [2:0] t);
      for (int l = 0; l < LANES; l++) map_mem[r][l] = t;
   endtask

   function automatic int m_lane();
      return (m_x + LANE_W/2) / LANE_W;
   endfunction

   function automatic int m_row();
      return m_y >> ROW_SHIFT;
   endfunction

   // One accepted frame, straight from the game rules.
   task automatic m_tick(input bit ml, input bit mr);
      int s, tile;
      if (m_st == 3) return;
      if (m_st != 2) begin
         if (mr && !ml)      m_x = (m_x + X_STEP > X_MAX) ? X_MAX : m_x + X_STEP;
         else if (ml && !mr) m_x = (m_x < X_STEP) ? 0 : m_x - X_STEP;
         m_y = (m_y + ((m_boost > 0) ? 2*SPEED : SPEED)) % (1 << Y_W);
      end
      if (m_boost > 0) m_boost--;
      if (m_st == 1) begin
         s = m_off + m_vz;
         if (s <= 0) begin m_off = 0; m_land = 1; end
         else m_off = (s > 511) ? 511 : s;
         m_vz -= GRAVITY;
      end
      if (m_st == 2 && m_fall > 0) m_fall--;
      tile = int'(map_mem[m_row()][m_lane()]);
      if (m_st == 0 || (m_st == 1 && m_land == 1)) begin
         m_land = 0;
         if (tile == 0) begin m_st = 2; m_fall = FALL_FRAMES; m_vz = 0; end
         else if (tile == 2) begin m_st = 1; m_vz = JUMP_V; end
         else begin
            m_st = 0; m_vz = 0;
            if (tile == 3) m_boost = BOOST_FRAMES;
         end
      end else if (m_st == 2 && m_fall == 0) begin
         m_st = 3; m_fail = 1;
      end
   endtask

   task automatic check_all();
      chk("x_ball", x_ball, m_x);
      chk("y_ball", y_ball, m_y);
      chk("offset", y_pixel_offset, m_off);
      chk("state", state, m_st);
      chk("boosted", boosted, (m_boost > 0) ? 1 : 0);
      chk("fail", fail, m_fail);
      chk("busy_idle", busy, 0);
      chk("idx_x", mif.map_index_x, m_lane());
      chk("idx_y", mif.map_index_y, m_row());
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; tick = 1'b0; move_left = 1'b0; move_right = 1'b0; pause = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_x = 200; m_y = 0; m_off = 0; m_st = 0; m_vz = 0;
      m_boost = 0; m_fall = 0; m_land = 0; m_fail = 0;
      check_all();
   endtask

   task automatic do_tick(input bit ml, input bit mr, input bit pz);
      int bc;
      bit acc;
      acc = !pz && (m_st != 3);
      @(negedge clk);
      move_left = ml; move_right = mr; pause = pz; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      bc = 0;
      for (int i = 0; i < 6; i++) begin
         if (busy === 1'b1) bc++;
         @(negedge clk);
      end
      pause = 1'b0;
      if (acc) m_tick(ml, mr);
      chk("busy_cycles", bc, acc ? 3 : 0);
      check_all();
   endtask

   initial begin
      int offs [0:63];
      int sts  [0:63];
      int prev_y;
      int d160, d161;
      bit [1:0] k;
      rst = 1'b1; tick = 1'b0; move_left = 1'b0; move_right = 1'b0; pause = 1'b0;

      // Reset and plain forward roll
      fill_map(3'd1);
      do_reset();
      chk("reset_x", x_ball, 200);
      for (int i = 0; i < 10; i++) do_tick(0, 0, 0);
      chk("y_after_10", y_ball, 20);

      // Random steering, then saturation and both-held
      for (int i = 0; i < 30; i++) begin
         k = 2'($urandom_range(0, 3));
         do_tick(k[0], k[1], 0);
      end
      for (int i = 0; i < 60; i++) do_tick(0, 1, 0);
      chk("x_sat", x_ball, 400);
      chk("idx_sat", mif.map_index_x, 4);
      for (int i = 0; i < 5; i++) do_tick(1, 1, 0);
      chk("x_both", x_ball, 400);

      // Jump pad at row 1: launch on tick 16, land on tick 41
      fill_map(3'd1); set_row(1, 3'd2);
      do_reset();
      for (int i = 1; i <= 45; i++) begin
         do_tick(0, 0, 0);
         offs[i] = int'(y_pixel_offset); sts[i] = int'(state);
      end
      chk("launch_state", sts[16], 1);
      chk("off_t1", offs[17], 12);
      chk("off_t2", offs[18], 23);
      chk("off_t3", offs[19], 33);
      chk("peak_t12", offs[28], 78);
      chk("peak_t13", offs[29], 78);
      chk("air_t24", sts[40], 1);
      chk("land_off", offs[41], 0);
      chk("land_state", sts[41], 0);

      // Hole at the landing row
      set_row(2, 3'd0);
      do_reset();
      for (int i = 1; i <= 70; i++) do_tick(0, 0, 0);
      chk("falling", state, 2);
      chk("no_fail_yet", fail, 0);
      do_tick(0, 0, 0);
      chk("dead", state, 3);
      chk("fail_set", fail, 1);
      for (int i = 0; i < 3; i++) do_tick(0, 1, 0);
      chk("fail_sticky", fail, 1);
      do_reset();
      chk("fail_cleared", fail, 0);

      // Boosted jump clears holes under the airborne path only
      fill_map(3'd1); set_row(0, 3'd3); set_row(1, 3'd2); set_row(2, 3'd0); set_row(3, 3'd0);
      do_reset();
      for (int i = 0; i < 40; i++) do_tick(0, 0, 0);
      chk("hole_jumped_fail", fail, 0);
      chk("hole_jumped_state", state, 0);

      // Boost window with a reload at row 4
      fill_map(3'd1); set_row(0, 3'd3); set_row(4, 3'd3);
      do_reset();
      prev_y = 0;
      d160 = 0; d161 = 0;
      for (int i = 1; i <= 165; i++) begin
         do_tick(0, 0, 0);
         if (i == 1) chk("step_t1", y_ball - prev_y, 2);
         if (i == 2) chk("step_t2", y_ball - prev_y, 4);
         if (i == 130) chk("reloaded", boosted, 1);
         if (i == 160) begin d160 = int'(y_ball) - prev_y; chk("boost_end", boosted, 0); end
         if (i == 161) d161 = int'(y_ball) - prev_y;
         prev_y = int'(y_ball);
      end
      chk("step_t160", d160, 4);
      chk("step_t161", d161, 2);

      // Tick while busy, then a paused tick
      fill_map(3'd1);
      do_reset();
      do_tick(0, 1, 0);
      prev_y = m_y;
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      repeat (4) @(negedge clk);
      m_tick(0, 1);
      check_all();
      chk("single_apply", y_ball, prev_y + 2);
      do_tick(0, 1, 1);
      chk("pause_y", y_ball, prev_y + 2);

      // Reset in the middle of a frame
      move_right = 1'b1;
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("midrst_x", x_ball, 200);
      chk("midrst_y", y_ball, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_state", state, 0);
      chk("midrst_idx", mif.map_index_x, 2);
      rst = 1'b0;
      m_x = 200; m_y = 0; m_off = 0; m_st = 0; m_vz = 0;
      m_boost = 0; m_fall = 0; m_land = 0; m_fail = 0;
      do_tick(0, 0, 0);

      // Random map and random controls against the model
      for (int r = 0; r < ROWS; r++)
         for (int l = 0; l < LANES; l++) begin
            int v;
            v = int'($urandom_range(0, 19));
            if (r == 0)       map_mem[r][l] = 3'd1;
            else if (v == 0)  map_mem[r][l] = 3'd0;
            else if (v == 1)  map_mem[r][l] = 3'd2;
            else if (v == 2)  map_mem[r][l] = 3'd3;
            else              map_mem[r][l] = 3'($urandom_range(4, 7));
         end
      do_reset();
      for (int i = 0; i < 150; i++) begin
         k = 2'($urandom_range(0, 3));
         do_tick(k[0], k[1], ($urandom_range(0, 7) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
